hack_video_ram: RTL and testbench
=================================

HACK_VIDEO_RAM -- requirements
Module: hack_video_ram

Interface
REQ-001 Parameter: DATA_W, 16, word width in bits.
REQ-002 Parameter: ADDR_W, 13, address width; DEPTH = 2**ADDR_W words.
REQ-003 Port: clock  input  1  sole clock, all state on rising edge.
REQ-004 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: cpu_addr  input  ADDR_W  CPU port word address.
REQ-006 Port: cpu_load  input  1  CPU write enable.
REQ-007 Port: cpu_in  input  DATA_W  CPU write data.
REQ-008 Port: cpu_out  output  DATA_W  CPU registered read data.
REQ-009 Port: scan_enable  input  1  permits the raster scan engine to fetch.
REQ-010 Port: scan_ready  input  1  display sink accepts current beat.
REQ-011 Port: scan_valid  output  1  scan_data/scan_addr/scan_sof hold a beat.
REQ-012 Port: scan_data  output  DATA_W  scanned pixel word.
REQ-013 Port: scan_addr  output  ADDR_W  address of the scanned word.
REQ-014 Port: scan_sof  output  1  beat is address 0 (start of frame).
REQ-015 Port: frame_done  output  1  one-cycle pulse when the beat at DEPTH-1 is accepted.
REQ-016 Port: clear_req  input  1  clear request (present only with HACK_VRAM_CLEAR_EN).
REQ-017 Port: busy  output  1  clear sweep in progress.

Function
REQ-018 CPU port SHALL have 1-cycle latency: write stores cpu_in and drives cpu_out=cpu_in next cycle (write-first); else cpu_out=mem[cpu_addr].
REQ-019 Scan engine SHALL keep pointer ptr; a fetch occurs when scan_enable && !busy && (!scan_valid || scan_ready), loading mem[ptr] into scan_data with scan_valid=1 next cycle and ptr=ptr+1 mod DEPTH.
REQ-020 Handshake: beat transfers when scan_valid && scan_ready; sustained ready SHALL give one word per cycle.
REQ-021 While scan_valid && !scan_ready, scan_data/scan_addr/scan_sof SHALL remain stable regardless of CPU writes.
REQ-022 Transfer with no fetch in the same cycle SHALL clear scan_valid.
REQ-023 scan_enable deassert SHALL not drop a pending beat; ptr retained, resumption continues at ptr.
REQ-024 Wrap: after DEPTH-1 next fetch is address 0 with scan_sof=1; frame_done pulses in the transfer cycle of address DEPTH-1.
REQ-025 Same-cycle CPU write and scan fetch of one address SHALL return old data to scan (read-before-write).

Reset
REQ-026 On reset_n low: cpu_out=0, scan_data=0, scan_addr=0, scan_valid=0, scan_sof=0, frame_done=0, busy=0, ptr=0, clear FSM IDLE; memory contents not reset.
REQ-027 Reset mid-frame or mid-clear SHALL abandon the operation; first fetch after release is address 0.

Configuration
REQ-028 Macro HACK_VRAM_CLEAR_EN defined: clear_req sampled high in IDLE starts FSM IDLE->CLEAR, writing 0 to addresses 0..DEPTH-1 one per cycle, busy=1 for exactly DEPTH cycles, then IDLE; clear_req ignored while busy.
REQ-029 During CLEAR: no new scan fetches (pending beat still held/transferable); ptr reset to 0 on CLEAR exit; same-cycle same-address CPU write overrides the clear write.
REQ-030 Macro undefined: clear_req port absent, busy tied 0, no clear logic.

Structure
REQ-031 Package hack_pkg SHALL hold HACK_DATA_W=16, HACK_SCREEN_ADDR_W=13 and the clear FSM state enum (IDLE, CLEAR).
REQ-032 Storage SHALL be sub-module hack_dpram (two synchronous ports, per-port write enable); scan and clear logic in hack_video_ram.

Verification
REQ-033 CPU write addr 5=16'hA5A5, read addr 5 next cycle -> cpu_out 16'hA5A5 both cycles.
REQ-034 Preload mem[i]=i, scan_enable=1, scan_ready=1 -> one beat/cycle, addrs 0..8191, scan_sof at 0, frame_done at 8191 transfer, then wrap to 0.
REQ-035 scan_ready low 3 cycles on addr 10 while CPU writes addr 10=16'hFFFF -> scan_data stays 10, no beat lost or duplicated.
REQ-036 Same cycle: CPU write addr 20=16'h1234 and scan fetch addr 20 (old 20) -> scan_data 20; following CPU read 16'h1234.
REQ-037 (CLEAR_EN) clear_req at frame midpoint -> busy 8192 cycles, no fetch, all words 0 except CPU-written addr 7=16'h0077 late in sweep; scan restarts at 0.
REQ-038 reset_n low mid-frame at addr 300 -> all outputs 0 immediately; after release first beat addr 0 with scan_sof=1.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared widths and clear-sweep FSM states for the Hack screen memory.
package hack_pkg;

    localparam int HACK_DATA_W        = 16;
    localparam int HACK_SCREEN_ADDR_W = 13;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/hack_video_ram_if.sv
// CPU word port plus the valid/ready raster scan stream of the video RAM.
interface hack_video_ram_if
    import hack_pkg::*;
#(
    parameter int DATA_W = HACK_DATA_W,
    parameter int ADDR_W = HACK_SCREEN_ADDR_W
) ();

    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_load;
    logic [DATA_W-1:0] cpu_in;
    logic [DATA_W-1:0] cpu_out;

    logic              scan_enable;
    logic              scan_ready;
    logic              scan_valid;
    logic [DATA_W-1:0] scan_data;
    logic [ADDR_W-1:0] scan_addr;
    logic              scan_sof;
    logic              frame_done;

    modport master (
        output cpu_addr, cpu_load, cpu_in,
        output scan_enable, scan_ready,
        input  cpu_out,
        input  scan_valid, scan_data, scan_addr,
        input  scan_sof, frame_done
    );

    modport slave (
        input  cpu_addr, cpu_load, cpu_in,
        input  scan_enable, scan_ready,
        output cpu_out,
        output scan_valid, scan_data, scan_addr,
        output scan_sof, frame_done
    );

endinterface

// File: rtl/hack_dpram.sv
// Two-port synchronous RAM: port a is write-first, port b reads old data.
module hack_dpram
    import hack_pkg::*;
#(
    parameter int DATA_W = HACK_DATA_W,
    parameter int ADDR_W = HACK_SCREEN_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_we,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_we,
    input  logic              b_re,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Port a is written last so a same-address collision keeps its data.
    always_ff @(posedge clock) begin
        if (b_we) mem[b_addr] <= b_wdata;
        if (a_we) mem[a_addr] <= a_wdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            a_rdata <= a_we ? a_wdata : mem[a_addr];
            if (b_re) b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/hack_video_ram.sv
// Hack screen RAM: CPU port plus raster scan stream; optional clear sweep
// built when HACK_VRAM_CLEAR_EN is defined.
module hack_video_ram
    import hack_pkg::*;
#(
    parameter int DATA_W = HACK_DATA_W,
    parameter int ADDR_W = HACK_SCREEN_ADDR_W
) (
    input  logic            clock,
    input  logic            reset_n,
    hack_video_ram_if.slave bus,
`ifdef HACK_VRAM_CLEAR_EN
    input  logic            clear_req,
`endif
    output logic            busy
);

    logic [ADDR_W-1:0] ptr;
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic              sof_q;
    logic              fetch;
    logic              xfer;
    logic              clr_we;
    logic              clr_done;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] a_rdata;
    logic [DATA_W-1:0] b_rdata;

    assign xfer  = valid_q && bus.scan_ready;
    assign fetch = bus.scan_enable && !busy
                && (!valid_q || bus.scan_ready);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr     <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            sof_q   <= 1'b0;
        end else begin
            if (fetch) begin
                valid_q <= 1'b1;
                addr_q  <= ptr;
                sof_q   <= (ptr == '0);
                ptr     <= ptr + 1'b1;
            end else begin
                if (xfer) valid_q <= 1'b0;
                if (clr_done) ptr <= '0;
            end
        end
    end

`ifdef HACK_VRAM_CLEAR_EN
    clr_state_t        state;
    clr_state_t        state_next;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        clr_we       = 1'b0;
        clr_done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next   = CLEAR;
                    clr_cnt_next = '0;
                end
            end
            CLEAR: begin
                clr_we       = 1'b1;
                clr_cnt_next = clr_cnt + 1'b1;
                if (clr_cnt == '1) begin
                    clr_done   = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    assign busy     = (state == CLEAR);
    assign clr_addr = clr_cnt;
`else
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_done = 1'b0;
    assign clr_addr = '0;
`endif

    // Port b is shared: the clear sweep owns it while busy, the scan otherwise.
    assign b_addr = busy ? clr_addr : ptr;

    hack_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dpram (
        .clock   (clock),
        .reset_n (reset_n),
        .a_addr  (bus.cpu_addr),
        .a_we    (bus.cpu_load),
        .a_wdata (bus.cpu_in),
        .a_rdata (a_rdata),
        .b_addr  (b_addr),
        .b_we    (clr_we),
        .b_re    (fetch),
        .b_wdata ('0),
        .b_rdata (b_rdata)
    );

    assign bus.cpu_out    = a_rdata;
    assign bus.scan_valid = valid_q;
    assign bus.scan_data  = b_rdata;
    assign bus.scan_addr  = addr_q;
    assign bus.scan_sof   = sof_q;
    assign bus.frame_done = xfer && (addr_q == '1);

endmodule

// File: tb/tb_hack_video_ram.sv
// Directed scoreboard bench for hack_video_ram.
module tb_hack_video_ram;
    import hack_pkg::*;

    localparam int DW    = HACK_DATA_W;
    localparam int AW    = HACK_SCREEN_ADDR_W;
    localparam int DEPTH = 2**AW;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          sof;
        logic          fd;
    } beat_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic busy;
`ifdef HACK_VRAM_CLEAR_EN
    logic clear_req = 1'b0;
`endif

    hack_video_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    hack_video_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
`ifdef HACK_VRAM_CLEAR_EN
        .clear_req (clear_req),
`endif
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int            compared   = 0;
    int            mismatched = 0;
    beat_t         sb[$];
    logic [DW-1:0] mem_m [DEPTH];
    logic [AW-1:0] exp_ptr;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        beat_t o;
        beat_t e;
        #1;
        if (bus.scan_valid && bus.scan_ready) begin
            o = {bus.scan_data, bus.scan_addr, bus.scan_sof, bus.frame_done};
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $error("FAIL extra_beat observed=%0h expected=none", o);
            end else begin
                e = sb.pop_front();
                chk("scan_beat", 64'(o), 64'(e));
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic push_beats(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = mem_m[exp_ptr];
            b.addr = exp_ptr;
            b.sof  = (exp_ptr == '0);
            b.fd   = (exp_ptr == '1);
            sb.push_back(b);
            exp_ptr = exp_ptr + 1'b1;
        end
    endtask

    task automatic run_empty(input string tag, input int budget);
        int k;
        k = 0;
        while (sb.size() != 0 && k < budget) begin
            cycle();
            k++;
        end
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $error("FAIL %s_timeout observed=%0d left expected=0",
                   tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic stream(input int n);
        bus.scan_enable = 1'b1;
        bus.scan_ready  = 1'b1;
        push_beats(n);
        run_empty("stream", n + 16);
    endtask

    task automatic drain();
        bus.scan_enable = 1'b0;
        bus.scan_ready  = 1'b1;
        push_beats(1);
        run_empty("drain", 8);
        chk("drain_idle", bus.scan_valid, 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_cpu_out"}, bus.cpu_out, 0);
        chk({tag, "_valid"}, bus.scan_valid, 0);
        chk({tag, "_data"}, bus.scan_data, 0);
        chk({tag, "_addr"}, bus.scan_addr, 0);
        chk({tag, "_sof"}, bus.scan_sof, 0);
        chk({tag, "_frame_done"}, bus.frame_done, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        bus.cpu_addr    = '0;
        bus.cpu_load    = 1'b0;
        bus.cpu_in      = '0;
        bus.scan_enable = 1'b0;
        bus.scan_ready  = 1'b0;
        exp_ptr         = '0;
        repeat (2) @(posedge clock);
        #1;
        chk_outputs_zero("rst");
        reset_n = 1'b1;

        // Write-first echo, then a plain read of the same word.
        bus.cpu_addr = 13'd5;
        bus.cpu_in   = 16'hA5A5;
        bus.cpu_load = 1'b1;
        cycle();
        chk("cpu_write_echo", bus.cpu_out, 16'hA5A5);
        bus.cpu_load = 1'b0;
        cycle();
        chk("cpu_read", bus.cpu_out, 16'hA5A5);

        for (int i = 0; i < DEPTH; i++) begin
            bus.cpu_addr = AW'(i);
            bus.cpu_in   = DW'(i);
            bus.cpu_load = 1'b1;
            mem_m[i]     = DW'(i);
            cycle();
            if (i % 1024 == 0) chk("preload_echo", bus.cpu_out, i);
        end
        bus.cpu_load = 1'b0;

        // Full frame at one beat per cycle, wrapping back to address 0.
        exp_ptr = '0;
        stream(DEPTH + 1);
        drain();

        // Stall on address 10 while the CPU overwrites it.
        stream(8);
        push_beats(1);
        bus.scan_ready = 1'b0;
        bus.cpu_addr   = 13'd10;
        bus.cpu_in     = 16'hFFFF;
        bus.cpu_load   = 1'b1;
        mem_m[10]      = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_data", bus.scan_data, 10);
            chk("stall_addr", bus.scan_addr, 10);
            chk("stall_valid", bus.scan_valid, 1);
        end
        chk("stall_cpu_echo", bus.cpu_out, 16'hFFFF);
        bus.cpu_load   = 1'b0;
        bus.scan_ready = 1'b1;
        push_beats(2);
        run_empty("stall_resume", 16);
        drain();

        // CPU write and scan fetch of address 20 on the same edge.
        stream(5);
        push_beats(2);
        bus.cpu_addr = 13'd20;
        bus.cpu_in   = 16'h1234;
        bus.cpu_load = 1'b1;
        cycle();
        mem_m[20]    = 16'h1234;
        bus.cpu_load = 1'b0;
        chk("rbw_cpu_echo", bus.cpu_out, 16'h1234);
        cycle();
        chk("rbw_cpu_read", bus.cpu_out, 16'h1234);
        run_empty("rbw", 4);
        drain();

        // Asynchronous reset with beat 300 pending.
        stream(278);
        chk("pre_reset_addr", bus.scan_addr, 300);
        #2;
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        @(posedge clock);
        #1;
        reset_n  = 1'b1;
        exp_ptr  = '0;
        stream(2);
        chk("mem_retained", bus.cpu_out, 16'h1234);
        drain();

`ifdef HACK_VRAM_CLEAR_EN
        begin
            int k;
            int stray;
            stream(4093);
            bus.scan_ready = 1'b0;
            push_beats(1);
            bus.scan_enable = 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            clear_req = 1'b1;
            cycle();
            k     = 0;
            stray = 0;
            while (busy && k < DEPTH + 16) begin
                bus.scan_ready = 1'b1;
                clear_req      = (k == 100);
                bus.cpu_load   = 1'b0;
                if (k == 8000) begin
                    bus.cpu_load = 1'b1;
                    bus.cpu_addr = 13'd8000;
                    bus.cpu_in   = 16'h0BEE;
                    mem_m[8000]  = 16'h0BEE;
                end else if (k == 8100) begin
                    bus.cpu_load = 1'b1;
                    bus.cpu_addr = 13'd7;
                    bus.cpu_in   = 16'h0077;
                    mem_m[7]     = 16'h0077;
                end
                if (k >= 1 && bus.scan_valid) stray++;
                cycle();
                k++;
            end
            clear_req    = 1'b0;
            bus.cpu_load = 1'b0;
            chk("clear_busy_cycles", k, DEPTH);
            chk("clear_no_fetch", stray, 0);
            chk("clear_valid_idle", bus.scan_valid, 0);
            for (int i = 0; i < DEPTH; i++) begin
                bus.cpu_addr = AW'(i);
                cycle();
                chk("clear_mem", bus.cpu_out, mem_m[i]);
            end
            exp_ptr = '0;
            stream(2);
            drain();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
